axi4_write_upsizer: RTL
=======================

// Module: axi4_write_upsizer
// PURPOSE
//  Write-channel companion of the AXI4 read-path width upsizer: accepts 32-bit AXI4 write bursts (AW/W/B) from a master.
//  Repacks pairs of 32-bit beats into 64-bit beats for a 64-bit slave (e.g. Axi4Memory) and returns the B response.
//  One outstanding transaction; INCR bursts of 4-byte beats only.
// PARAMETERS
//  ID_WIDTH    4   AXI ID width, both sides
//  ADDR_WIDTH  32  address width, both sides (data widths fixed 32 -> 64)
// PORTS
//  clock                               in   1    single clock
//  reset                               in   1    asynchronous, active-high
//  io_s_axi_aw_valid / _ready          in/out 1  slave AW handshake
//  io_s_axi_aw_bits_id / _addr / _len  in   ID/ADDR/4  slave AW fields (size=2, burst=INCR implied)
//  io_s_axi_w_valid / _ready           in/out 1  slave W handshake
//  io_s_axi_w_bits_data / _strb        in   32/4 slave write data, byte strobes
//  io_s_axi_w_bits_last                in   1    last slave beat
//  io_s_axi_b_valid / _ready           out/in 1  slave B handshake
//  io_s_axi_b_bits_id / _resp          out  ID/2 B id (from AW), response (from master B)
//  io_m_axi_aw_valid / _ready          out/in 1  master AW handshake
//  io_m_axi_aw_bits_id / _addr         out  ID/ADDR  latched id; addr with [2:0]=0
//  io_m_axi_aw_bits_len / _size        out  4/3  repacked length; size constant 3
//  io_m_axi_w_valid / _ready           out/in 1  master W handshake
//  io_m_axi_w_bits_data / _strb        out  64/8 packed data, strobes
//  io_m_axi_w_bits_last                out  1    last master beat
//  io_m_axi_b_valid / _ready           in/out 1  master B handshake
//  io_m_axi_b_bits_resp                in   2    master response (master B id ignored)
// BEHAVIOUR
//  - Reset: state=IDLE; all valids, readies, data, strb, last, resp, id, addr, len = 0. s_aw_ready rises the first clock after reset deasserts.
//  - Reset mid-burst: abort, discard packed data, return to IDLE; no B is issued for the aborted burst.
//  - FSM IDLE->AW->DATA->RESP->BRESP->IDLE.
//  - IDLE: s_aw_ready=1; on s_aw handshake latch id, addr, len, lane=addr[2].
//  - Master length: m_len = (addr[2] + len) >> 1 (5-bit sum, 4-bit result).
//    Examples: addr[2]=1, len=0 -> 0; addr[2]=1, len=1 -> 1.
//  - AW: m_aw_valid=1 held until m_aw_ready, then go to DATA. W ready is 0 outside DATA.
//  - DATA: s_w_ready = !m_w_valid. An accepted beat writes data/strb into lane (bits lane*32 +: 32, strb lane*4 +: 4).
//    - If lane==1 or s_w_last: register the 64-bit beat, set m_w_valid=1, m_w_last=s_w_last, lane<=0; else lane<=1.
//    - Unfilled lane: data 0, strb 0.
//    - On m_w handshake: clear the buffer and drop m_w_valid; if it was last, go to RESP.
//    - Throughput: 1 slave beat/cycle except one bubble while a packed beat waits on m_w_ready.
//  - RESP: m_b_ready=1; on m_b_valid latch resp, go to BRESP.
//  - BRESP: s_b_valid=1 with latched id/resp until s_b_ready, then IDLE. Latency from m_b handshake to s_b_valid: 1 cycle.
//  - m_w_last follows s_w_last only; a burst with an early or late s_w_last is a master protocol error, and no beat is dropped or invented.
// STRUCTURE
//  - Package axi4_width_pkg: state enum (IDLE, AW, DATA, RESP, BRESP), RESP_OKAY/RESP_SLVERR, M_SIZE=3'd3.
//  - Sub-module axi4_write_beat_packer: lane pointer and 64-bit data/strb/last buffer with m_w handshake. FSM stays in top.
// TESTING
//  1. addr=0x100, len=3, data 0x11..0x44, strb 0xF -> m_aw addr 0x100, len 1; m_w 0x22222222_11111111/0xFF, then 0x44444444_33333333/0xFF last; B OKAY, id echoed.
//  2. addr=0x104, len=0, data 0xAABBCCDD -> m_aw addr 0x100, len 0; m_w 0xAABBCCDD_00000000, strb 0xF0, last.
//  3. addr=0x104, len=2 -> m_len 1; beat0 strb 0xF0, beat1 strb 0xFF, last on beat1.
//  4. m_w_ready low 5 cycles mid-burst -> s_w_ready low for the same 5 cycles; no data loss; ordering kept.
//  5. m_b_resp=SLVERR, s_b_ready delayed 3 cycles -> s_b_valid held, resp=2, id stable; next AW not accepted until s_b handshake.
//  6. reset asserted during DATA -> all outputs 0 immediately; after release, a fresh len=0 burst completes normally.

Source files
------------

// File: rtl/axi4_width_pkg.sv
// Shared types and constants for the 32->64 bit AXI4 write upsizer.
// The master-side burst length helper lives here so the bench and RTL agree on one definition.
package axi4_width_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AW    = 3'd1,
    DATA  = 3'd2,
    RESP  = 3'd3,
    BRESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] M_SIZE      = 3'd3;

  // Number of 64-bit beats minus one, given the starting lane and the 32-bit beat count minus one.
  function automatic logic [3:0] m_len_calc(input logic lane, input logic [3:0] s_len);
    logic [4:0] sum;
    sum = {4'b0000, lane} + {1'b0, s_len};
    return sum[4:1];
  endfunction

endpackage

// File: rtl/axi4_write_beat_packer.sv
// Packs 32-bit write beats into 64-bit lanes and holds the packed beat until the master W accepts it.
module axi4_write_beat_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        lane_init_i,
  input  logic        en_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  input  logic [3:0]  s_strb_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  input  logic        m_ready_i,
  output logic        m_valid_o,
  output logic [63:0] m_data_o,
  output logic [7:0]  m_strb_o,
  output logic        m_last_o,
  output logic        done_o
);

  logic        lane_q;
  logic        valid_q;
  logic        last_q;
  logic [63:0] data_q;
  logic [7:0]  strb_q;
  logic        accept;
  logic        fire;

  // Slave beats are only taken while no packed beat is waiting, so accept and fire never coincide.
  assign s_ready_o = en_i && !valid_q;
  assign accept    = s_valid_i && s_ready_o;
  assign fire      = valid_q && m_ready_i;
  assign done_o    = fire && last_q;

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_strb_o  = strb_q;
  assign m_last_o  = last_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (start_i) begin
      lane_q  <= lane_init_i;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (fire) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      if (lane_q) begin
        data_q[63:32] <= s_data_i;
        strb_q[7:4]   <= s_strb_i;
      end else begin
        data_q[31:0]  <= s_data_i;
        strb_q[3:0]   <= s_strb_i;
      end
      // A last beat in the low lane ships half-filled; the empty lane stays zero with zero strobes.
      if (lane_q || s_last_i) begin
        valid_q <= 1'b1;
        last_q  <= s_last_i;
        lane_q  <= 1'b0;
      end else begin
        lane_q  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_write_upsizer.sv
// 32-bit AXI4 write slave to 64-bit AXI4 write master, one outstanding INCR burst of 4-byte beats.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both high; valid never waits on ready.
module axi4_write_upsizer
  import axi4_width_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_s_axi_aw_valid,
  output logic                  io_s_axi_aw_ready,
  input  logic [ID_WIDTH-1:0]   io_s_axi_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0] io_s_axi_aw_bits_addr,
  input  logic [3:0]            io_s_axi_aw_bits_len,
  input  logic                  io_s_axi_w_valid,
  output logic                  io_s_axi_w_ready,
  input  logic [31:0]           io_s_axi_w_bits_data,
  input  logic [3:0]            io_s_axi_w_bits_strb,
  input  logic                  io_s_axi_w_bits_last,
  output logic                  io_s_axi_b_valid,
  input  logic                  io_s_axi_b_ready,
  output logic [ID_WIDTH-1:0]   io_s_axi_b_bits_id,
  output logic [1:0]            io_s_axi_b_bits_resp,
  output logic                  io_m_axi_aw_valid,
  input  logic                  io_m_axi_aw_ready,
  output logic [ID_WIDTH-1:0]   io_m_axi_aw_bits_id,
  output logic [ADDR_WIDTH-1:0] io_m_axi_aw_bits_addr,
  output logic [3:0]            io_m_axi_aw_bits_len,
  output logic [2:0]            io_m_axi_aw_bits_size,
  output logic                  io_m_axi_w_valid,
  input  logic                  io_m_axi_w_ready,
  output logic [63:0]           io_m_axi_w_bits_data,
  output logic [7:0]            io_m_axi_w_bits_strb,
  output logic                  io_m_axi_w_bits_last,
  input  logic                  io_m_axi_b_valid,
  output logic                  io_m_axi_b_ready,
  input  logic [1:0]            io_m_axi_b_bits_resp,
  output state_e                dbg_state_o
);

  state_e                state_q;
  logic                  s_aw_ready_q;
  logic                  m_aw_valid_q;
  logic                  m_b_ready_q;
  logic                  s_b_valid_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:3] addr_q;
  logic [3:0]            len_q;
  logic [1:0]            resp_q;
  logic                  aw_fire;
  logic                  beat_done;
  logic [1:0]            unused_addr_bits;

  assign unused_addr_bits = io_s_axi_aw_bits_addr[1:0];
  assign aw_fire          = io_s_axi_aw_valid && s_aw_ready_q;

  assign io_s_axi_aw_ready     = s_aw_ready_q;
  assign io_s_axi_b_valid      = s_b_valid_q;
  assign io_s_axi_b_bits_id    = id_q;
  assign io_s_axi_b_bits_resp  = resp_q;
  assign io_m_axi_aw_valid     = m_aw_valid_q;
  assign io_m_axi_aw_bits_id   = id_q;
  assign io_m_axi_aw_bits_addr = {addr_q, 3'b000};
  assign io_m_axi_aw_bits_len  = len_q;
  assign io_m_axi_aw_bits_size = M_SIZE;
  assign io_m_axi_b_ready      = m_b_ready_q;
  assign dbg_state_o           = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_aw_ready_q <= 1'b0;
      m_aw_valid_q <= 1'b0;
      m_b_ready_q  <= 1'b0;
      s_b_valid_q  <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      resp_q       <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_fire) begin
            id_q         <= io_s_axi_aw_bits_id;
            addr_q       <= io_s_axi_aw_bits_addr[ADDR_WIDTH-1:3];
            len_q        <= m_len_calc(io_s_axi_aw_bits_addr[2], io_s_axi_aw_bits_len);
            s_aw_ready_q <= 1'b0;
            m_aw_valid_q <= 1'b1;
            state_q      <= AW;
          end else begin
            s_aw_ready_q <= 1'b1;
          end
        end
        AW: begin
          if (io_m_axi_aw_ready) begin
            m_aw_valid_q <= 1'b0;
            state_q      <= DATA;
          end
        end
        DATA: begin
          if (beat_done) begin
            m_b_ready_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (io_m_axi_b_valid) begin
            resp_q      <= io_m_axi_b_bits_resp;
            m_b_ready_q <= 1'b0;
            s_b_valid_q <= 1'b1;
            state_q     <= BRESP;
          end
        end
        BRESP: begin
          // Re-arm AW on the same edge so a back-to-back burst loses no cycle.
          if (io_s_axi_b_ready) begin
            s_b_valid_q  <= 1'b0;
            s_aw_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi4_write_beat_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .start_i     (aw_fire),
    .lane_init_i (io_s_axi_aw_bits_addr[2]),
    .en_i        (state_q == DATA),
    .s_valid_i   (io_s_axi_w_valid),
    .s_data_i    (io_s_axi_w_bits_data),
    .s_strb_i    (io_s_axi_w_bits_strb),
    .s_last_i    (io_s_axi_w_bits_last),
    .s_ready_o   (io_s_axi_w_ready),
    .m_ready_i   (io_m_axi_w_ready),
    .m_valid_o   (io_m_axi_w_valid),
    .m_data_o    (io_m_axi_w_bits_data),
    .m_strb_o    (io_m_axi_w_bits_strb),
    .m_last_o    (io_m_axi_w_bits_last),
    .done_o      (beat_done)
  );

endmodule
